alu_muldiv: RTL

Parametrised, sequential successor to the single-cycle ALU and ALU-control pair. It decodes the same `ALU_Op`/`FuncCode` encoding and executes the six single-cycle ALU operations with a registered result. It adds iterative signed and unsigned multiply and divide into internal `HI`/`LO` registers, plus `MFHI`/`MFLO` reads. It sits in the execute stage and stalls issue through a `start`/`busy`/`done` handshake.

---
 rtl/alu_muldiv.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// Sequential ALU with iterative signed/unsigned multiply and divide into HI/LO.
// Single-cycle ops finish in one clock; mul/div take WIDTH clocks behind busy/done.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       ALU_Op,
  input  logic [5:0]       FuncCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Output,
  output logic             Zero_Flag,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             error
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, mq_q, opnd_q;
  logic [WIDTH-1:0] out_q, hi_q, lo_q;
  logic             zf_q, busy_q, done_q, error_q;
  logic             div_q, neg_q, negr_q, dz_q;

  logic [WIDTH-1:0] alu_res;
  logic             is_md, is_div, is_sgn, invalid;

  always_comb begin
    alu_res = '0;
    is_md   = 1'b0;
    is_div  = 1'b0;
    is_sgn  = 1'b0;
    invalid = 1'b0;
    case (ALU_Op)
      2'b00: alu_res = A + B;
      2'b01: alu_res = A - B;
      2'b10: begin
        case (FuncCode)
          6'b100000: alu_res = A + B;
          6'b100010: alu_res = A - B;
          6'b100100: alu_res = A & B;
          6'b100101: alu_res = A | B;
          6'b101010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
          6'b100111: alu_res = ~(A | B);
          6'b011000: begin is_md = 1'b1; is_sgn = 1'b1; end
          6'b011001: is_md = 1'b1;
          6'b011010: begin is_md = 1'b1; is_div = 1'b1; is_sgn = 1'b1; end
          6'b011011: begin is_md = 1'b1; is_div = 1'b1; end
          6'b010000: alu_res = hi_q;
          6'b010010: alu_res = lo_q;
          default:   invalid = 1'b1;
        endcase
      end
      default: invalid = 1'b1;
    endcase
  end

  // Both engines iterate on magnitudes; signs are reapplied on the last step.
  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign sa    = is_sgn & A[WIDTH-1];
  assign sb    = is_sgn & B[WIDTH-1];
  assign abs_a = sa ? -A : A;
  assign abs_b = sb ? -B : B;

  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH-1:0]   div_sub, acc_d, mq_d;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo, rem, hi_d, lo_d;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc_q, mq_q[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, opnd_q};
    div_sub  = div_sh[WIDTH-1:0] - opnd_q;
    acc_d    = div_q ? (div_ge ? div_sub : div_sh[WIDTH-1:0]) : mul_sum[WIDTH:1];
    mq_d     = div_q ? {mq_q[WIDTH-2:0], div_ge} : {mul_sum[0], mq_q[WIDTH-1:1]};
    prod     = {acc_d, mq_d};
    prod_fix = neg_q ? -prod : prod;
    // A zero divisor yields an all-ones quotient and the dividend as remainder.
    quo      = dz_q ? '1 : (neg_q ? -mq_d : mq_d);
    rem      = negr_q ? -acc_d : acc_d;
    hi_d     = div_q ? rem : prod_fix[2*WIDTH-1:WIDTH];
    lo_d     = div_q ? quo : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      opnd_q  <= '0;
      out_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zf_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_md) begin
              state_q <= S_BUSY;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              acc_q   <= '0;
              mq_q    <= abs_a;
              opnd_q  <= abs_b;
              div_q   <= is_div;
              neg_q   <= sa ^ sb;
              negr_q  <= sa;
              dz_q    <= is_div && (B == '0);
            end else begin
              done_q  <= 1'b1;
              error_q <= invalid;
              out_q   <= invalid ? '0 : alu_res;
              zf_q    <= !invalid && (alu_res == '0);
            end
          end
        end
        S_BUSY: begin
          acc_q <= acc_d;
          mq_q  <= mq_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Output    = out_q;
  assign Zero_Flag = zf_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
endmodule
